// File: rtl/niosii_system_de2_pulse_out_if.sv
// Avalon-MM slave bus bundle for the pulse output peripheral.
interface niosii_system_de2_pulse_out_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/niosii_system_de2_pulse_out.sv
// Eight-line static/pulse output port with per-bit one-shot timers and done interrupt.
// Optional feature macro: PULSE_OUT_IRQ_EN (IRQ_MASK register and irq output).
module niosii_system_de2_pulse_out #(
    parameter logic [15:0] DEFAULT_WIDTH = 16'd100
) (
    input  logic                          clk,
    input  logic                          reset_n,
    niosii_system_de2_pulse_out_if.slave  bus,
    output logic [7:0]                    out_port,
    output logic                          irq
);
    localparam int unsigned NBITS = 8;
    localparam int unsigned CW    = 16;
    localparam int unsigned DW    = 32;

    logic [NBITS-1:0]         data_q;
    logic [NBITS-1:0]         done_q, done_d;
    logic [CW-1:0]            width_q;
    logic [NBITS-1:0][CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]            readdata_q, readdata_d;
    logic [NBITS-1:0]         mask_c;

    logic                     wr_c;
    logic [NBITS-1:0]         start_c, clr_c, done_set_c, busy_c;
    logic                     unused_wdata_c;

    assign unused_wdata_c = ^bus.writedata[DW-1:CW];

    // Write decode
    always_comb begin
        wr_c    = bus.chipselect && !bus.write_n;
        start_c = '0;
        clr_c   = '0;
        if (wr_c && bus.address == 2'd1) begin
            start_c = bus.writedata[NBITS-1:0];
            clr_c   = bus.writedata[2*NBITS-1:NBITS];
        end
    end

    // A start reloads the counter even mid-pulse; WIDTH=0 completes immediately
    always_comb begin
        cnt_d      = cnt_q;
        done_set_c = '0;
        busy_c     = '0;
        for (int i = 0; i < int'(NBITS); i++) begin
            busy_c[i] = (cnt_q[i] != '0);
            if (start_c[i]) begin
                cnt_d[i]      = width_q;
                done_set_c[i] = (width_q == '0);
            end else if (cnt_q[i] != '0) begin
                cnt_d[i]      = cnt_q[i] - CW'(1);
                done_set_c[i] = (cnt_q[i] == CW'(1));
            end
        end
        done_d = (done_q & ~clr_c) | done_set_c;
    end

    always_comb begin
        readdata_d = '0;
        case (bus.address)
            2'd0:    readdata_d = DW'(data_q);
            2'd1:    readdata_d = DW'({done_q, busy_c});
            2'd2:    readdata_d = DW'(mask_c);
            default: readdata_d = DW'(width_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            done_q     <= '0;
            width_q    <= DEFAULT_WIDTH;
            cnt_q      <= '0;
            readdata_q <= '0;
        end else begin
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            if (wr_c && bus.address == 2'd0) data_q  <= bus.writedata[NBITS-1:0];
            if (wr_c && bus.address == 2'd3) width_q <= bus.writedata[CW-1:0];
        end
    end

`ifdef PULSE_OUT_IRQ_EN
    logic [NBITS-1:0] mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if (wr_c && bus.address == 2'd2) begin
            mask_q <= bus.writedata[NBITS-1:0];
        end
    end

    assign mask_c = mask_q;
    assign irq    = |(done_q & mask_q);
`else
    assign mask_c = '0;
    assign irq    = 1'b0;
`endif

    assign bus.readdata = readdata_q;
    assign out_port     = data_q | busy_c;

endmodule

// File: tb/tb_niosii_system_de2_pulse_out.sv
// Self-checking bench: timestamp-based reference model plus directed and random traffic.
module tb_niosii_system_de2_pulse_out;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] out_port;
    logic       irq;

    niosii_system_de2_pulse_out_if bus();

    niosii_system_de2_pulse_out #(.DEFAULT_WIDTH(16'd100)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: each bit remembers the cycle number at which its pulse ends
    int          now = 0;
    int          end_cyc [8] = '{default: 0};
    logic [7:0]  m_data  = '0;
    logic [7:0]  m_mask  = '0;
    logic [7:0]  m_done  = '0;
    logic [15:0] m_width = 16'd100;
    logic [31:0] m_rd    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = (end_cyc[i] > now);
        return b;
    endfunction

    function automatic logic m_irq();
`ifdef PULSE_OUT_IRQ_EN
        return |(m_done & m_mask);
`else
        return 1'b0;
`endif
    endfunction

    initial begin : model
        logic        wr;
        logic [31:0] wd;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                now = 0;
                for (int i = 0; i < 8; i++) end_cyc[i] = 0;
                m_data = '0; m_mask = '0; m_done = '0; m_width = 16'd100; m_rd = '0;
            end else begin
                wr = (bus.chipselect === 1'b1) && (bus.write_n === 1'b0);
                wd = bus.writedata;
                case (bus.address)
                    2'd0:    m_rd = {24'h0, m_data};
                    2'd1:    m_rd = {16'h0, m_done, m_busy()};
`ifdef PULSE_OUT_IRQ_EN
                    2'd2:    m_rd = {24'h0, m_mask};
`else
                    2'd2:    m_rd = '0;
`endif
                    default: m_rd = {16'h0, m_width};
                endcase
                now++;
                if (wr && bus.address == 2'd1) m_done = m_done & ~wd[15:8];
                for (int i = 0; i < 8; i++) begin
                    if (wr && bus.address == 2'd1 && wd[i]) begin
                        end_cyc[i] = now + int'(m_width);
                        if (m_width == 16'd0) m_done[i] = 1'b1;
                    end else if (end_cyc[i] == now) begin
                        m_done[i] = 1'b1;
                    end
                end
                if (wr) begin
                    case (bus.address)
                        2'd0: m_data = wd[7:0];
`ifdef PULSE_OUT_IRQ_EN
                        2'd2: m_mask = wd[7:0];
`endif
                        2'd3: m_width = wd[15:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("out_port", 32'(out_port), 32'(m_data | m_busy()));
            chk("readdata", bus.readdata, m_rd);
            chk("irq", 32'(irq), 32'(m_irq()));
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b0; bus.write_n = 1'b1;
        @(negedge clk);
        d = bus.readdata;
    endtask

    initial begin : stim
        logic [31:0] d;
        logic [7:0]  prev_out;
        logic        prev_done;
        int          cnt, rises;
        bit          all_high;

        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(negedge clk);
        chk("rst out_port", 32'(out_port), 32'h0);
        chk("rst readdata", bus.readdata, 32'h0);
        chk("rst irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        rd(2'd3, d);
        chk("default width", d, 32'd100);

        // Three-cycle pulse on bit 0
        wr(2'd3, 32'd3);
        wr(2'd1, 32'h01);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_port[0]) cnt++;
            @(negedge clk);
        end
        chk("pulse3 cycles", 32'(cnt), 32'd3);
        rd(2'd1, d);
        chk("pulse3 status", d, 32'h0100);

`ifdef PULSE_OUT_IRQ_EN
        wr(2'd2, 32'h01);
        wr(2'd1, 32'hFF00);
        wr(2'd1, 32'h01);
        repeat (2) @(negedge clk);
        chk("irq before done", 32'(irq), 32'h0);
        @(negedge clk);
        chk("irq on done", 32'(irq), 32'h1);
        wr(2'd1, 32'h0100);
        chk("irq after clear", 32'(irq), 32'h0);
        wr(2'd2, 32'h00);
`else
        wr(2'd2, 32'hFF);
        rd(2'd2, d);
        chk("mask absent", d, 32'h0);
        chk("irq tied", 32'(irq), 32'h0);
`endif

        // Retrigger extends the bit-2 pulse to 15 cycles with one completion
        wr(2'd3, 32'd10);
        wr(2'd1, 32'h04);
        cnt = 0; rises = 0; prev_done = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k == 4) begin
                bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = 32'h04;
            end
            if (k == 5) begin
                bus.chipselect = 1'b0; bus.write_n = 1'b1;
            end
            if (out_port[2]) cnt++;
            if (bus.readdata[10] && !prev_done) rises++;
            prev_done = bus.readdata[10];
            @(negedge clk);
        end
        chk("retrigger cycles", 32'(cnt), 32'd15);
        chk("retrigger done sets", 32'(rises), 32'd1);

        // Static level and pulse overlap on bit 7
        wr(2'd3, 32'd5);
        wr(2'd0, 32'h80);
        wr(2'd1, 32'h80);
        all_high = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!out_port[7]) all_high = 1'b0;
            @(negedge clk);
        end
        chk("bit7 held high", 32'(all_high), 32'h1);
        rd(2'd1, d);
        chk("bit7 done", 32'(d[15]), 32'h1);

        // Zero width: no pulse, immediate done
        wr(2'd1, 32'hFF00);
        wr(2'd3, 32'd0);
        prev_out = out_port;
        wr(2'd1, 32'h10);
        chk("w0 out unchanged", 32'(out_port), 32'(prev_out));
        @(negedge clk);
        chk("w0 status", bus.readdata, 32'h1000);

        // Reset in the middle of a long pulse
        wr(2'd0, 32'h0);
        wr(2'd3, 32'd100);
        wr(2'd1, 32'h01);
        repeat (49) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mid rst out_port", 32'(out_port), 32'h0);
        chk("mid rst readdata", bus.readdata, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(2'd3, d);
        chk("post rst width", d, 32'd100);
        rd(2'd1, d);
        chk("post rst done", d, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            bus.address   = 2'($urandom_range(0, 3));
            bus.writedata = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                bus.chipselect = 1'b1; bus.write_n = 1'b0;
                if (bus.address == 2'd1) begin
                    bus.writedata[7:0]  = bus.writedata[7:0] & 8'($urandom) & 8'($urandom);
                    bus.writedata[15:8] = bus.writedata[15:8] & 8'($urandom);
                end
                if (bus.address == 2'd3) bus.writedata[15:0] = 16'($urandom_range(0, 12));
            end else begin
                bus.chipselect = 1'($urandom_range(0, 1));
                bus.write_n    = 1'b1;
            end
        end
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
